// File: rtl/opb_register_bank_simulink2ppc.sv
// Read-only OPB register bank: captures C_NUM_REGS fabric words into a coherent snapshot bank.
// Optional overrun STATUS register is built when OVF_STATUS_EN is defined.
module opb_register_bank_simulink2ppc #(
    parameter int                      C_OPB_AWIDTH  = 32,
    parameter int                      C_OPB_DWIDTH  = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR    = 32'h01008100,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR    = 32'h010081FF,
    parameter int                      C_NUM_REGS    = 4,
    parameter int                      C_USER_DWIDTH = 32,
    parameter string                   C_FAMILY      = "virtex5"
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]               OPB_ABus,
    input  logic [0:3]                            OPB_BE,
    input  logic [0:31]                           OPB_DBus,
    input  logic                                  OPB_RNW,
    input  logic                                  OPB_select,
    input  logic                                  OPB_seqAddr,
    output logic [0:31]                           Sl_DBus,
    output logic                                  Sl_xferAck,
    output logic                                  Sl_errAck,
    output logic                                  Sl_retry,
    output logic                                  Sl_toutSup,
    input  logic [C_NUM_REGS*C_USER_DWIDTH-1:0]   user_data_in,
    input  logic [C_NUM_REGS-1:0]                 user_valid
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
    state_t state, state_nxt;

    logic [C_OPB_AWIDTH-1:0] addr, off;
    logic [31:0] wdata, rd_val, status_val;
    logic        in_win, ack, wr_ctrl, snap_req, auto_en;
    logic [C_NUM_REGS-1:0][C_USER_DWIDTH-1:0] shadow, shadow_nxt, snap;

    // Vector assignment maps big-endian bus bit 31 onto the value LSB.
    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign in_win = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign off    = (addr - C_BASEADDR) >> 2;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (OPB_select && in_win) state_nxt = ACK;
            ACK:     state_nxt = WAIT;
            WAIT:    if (!OPB_select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset during the ACK cycle suppresses the acknowledge of the aborted transfer.
    always_comb begin
        ack = 1'b0;
        if (state == ACK && !OPB_Rst) ack = 1'b1;
    end

    assign Sl_xferAck = ack;
    assign Sl_DBus    = ack ? rd_val : 32'h0;
    assign wr_ctrl    = ack && !OPB_RNW && (off == C_NUM_REGS) && OPB_BE[3];

    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (user_valid[i]) shadow_nxt[i] = user_data_in[i*C_USER_DWIDTH +: C_USER_DWIDTH];
    end

    // The snapshot copies the post-capture shadow, so a same-cycle capture is included.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            shadow   <= '0;
            snap     <= '0;
            auto_en  <= 1'b1;
            snap_req <= 1'b0;
        end else begin
            shadow   <= shadow_nxt;
            if (auto_en || snap_req) snap <= shadow_nxt;
            snap_req <= wr_ctrl && wdata[1];
            if (wr_ctrl) auto_en <= wdata[0];
        end
    end

`ifdef OVF_STATUS_EN
    logic [C_NUM_REGS-1:0] pend, ovf;
    logic [31:0] be_mask;
    logic        wr_stat;

    assign be_mask = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};
    assign wr_stat = ack && !OPB_RNW && (off == C_NUM_REGS + 1);

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (auto_en || snap_req) pend[i] <= 1'b0;
                else if (user_valid[i])  pend[i] <= 1'b1;
                if (user_valid[i] && !auto_en && pend[i])
                    ovf[i] <= 1'b1;
                else if (wr_stat && wdata[31-i] && be_mask[31-i])
                    ovf[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        status_val = '0;
        for (int i = 0; i < C_NUM_REGS; i++) status_val[31-i] = ovf[i];
    end
`else
    assign status_val = '0;
`endif

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (off == i) rd_val[C_USER_DWIDTH-1:0] = snap[i];
        if (off == C_NUM_REGS)     rd_val[0] = auto_en;
        if (off == C_NUM_REGS + 1) rd_val    = status_val;
    end

    logic unused;
    assign unused = ^{OPB_seqAddr, wdata, OPB_BE};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Scoreboard bench for opb_register_bank_simulink2ppc: reads push expectations, the ack monitor pops them.
module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] BASE = 32'h01008100;
    localparam logic [31:0] HIGH = 32'h010081FF;
    localparam int N = 4;
    localparam int W = 16;
    localparam int CTRL = N;
    localparam int STAT = N + 1;

`ifdef OVF_STATUS_EN
    localparam logic [31:0] OVF_EXP = 32'h40000000;
`else
    localparam logic [31:0] OVF_EXP = 32'h0;
`endif

    logic          OPB_Clk = 1'b0;
    logic          OPB_Rst = 1'b1;
    logic [0:31]   OPB_ABus = '0;
    logic [0:3]    OPB_BE = '0;
    logic [0:31]   OPB_DBus = '0;
    logic          OPB_RNW = 1'b1;
    logic          OPB_select = 1'b0;
    logic          OPB_seqAddr = 1'b0;
    logic [0:31]   Sl_DBus;
    logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [N*W-1:0] user_data_in = '0;
    logic [N-1:0]  user_valid = '0;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 OPB_Clk = ~OPB_Clk;

    opb_register_bank_simulink2ppc #(
        .C_NUM_REGS(N), .C_USER_DWIDTH(W)
    ) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
        .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_in(user_data_in), .user_valid(user_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Read acks pop the scoreboard; outside an ack the data bus must be zero.
    always @(negedge OPB_Clk) begin
        if (Sl_xferAck) begin
            acks++;
            if (OPB_RNW) begin
                if (exp_q.size() == 0) chk("unexpected_read_ack", 32'd1, 32'd0);
                else chk(tag_q.pop_front(), Sl_DBus, exp_q.pop_front());
            end
        end else if (!OPB_Rst) begin
            chk("dbus_idle", Sl_DBus, 32'h0);
        end
    end

    task automatic xfer(input logic rnw, input int off, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp, input string tag,
                        input int hold);
        int n, a0;
        @(posedge OPB_Clk); #1;
        a0 = acks;
        OPB_ABus = BASE + 32'(off * 4);
        OPB_RNW = rnw; OPB_DBus = wd; OPB_BE = be; OPB_select = 1'b1;
        if (rnw) begin exp_q.push_back(exp); tag_q.push_back(tag); end
        @(posedge OPB_Clk);
        n = 0;
        do begin @(negedge OPB_Clk); n++; end while (!Sl_xferAck && n < 8);
        chk({tag, "_latency"}, 32'(n), 32'd1);
        if (!Sl_xferAck && rnw && exp_q.size() > 0) begin
            void'(exp_q.pop_back()); void'(tag_q.pop_back());
        end
        repeat (hold) @(posedge OPB_Clk);
        @(posedge OPB_Clk); #1;
        OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_DBus = '0;
        repeat (2) @(negedge OPB_Clk);
        chk({tag, "_ack_count"}, 32'(acks - a0), 32'd1);
    endtask

    task automatic rd(input int off, input logic [31:0] exp, input string tag);
        xfer(1'b1, off, 32'h0, 4'b1111, exp, tag, 0);
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be, input string tag);
        xfer(1'b0, off, d, be, 32'h0, tag, 0);
    endtask

    task automatic cap(input int ch, input logic [W-1:0] d);
        @(posedge OPB_Clk); #1;
        user_data_in[ch*W +: W] = d;
        user_valid = N'(1) << ch;
        @(posedge OPB_Clk); #1;
        user_valid = '0;
    endtask

    task automatic out_of_window(input logic [31:0] a, input string tag);
        int a0;
        @(posedge OPB_Clk); #1;
        a0 = acks;
        OPB_ABus = a; OPB_RNW = 1'b1; OPB_select = 1'b1;
        repeat (4) @(posedge OPB_Clk);
        #1 OPB_select = 1'b0;
        @(negedge OPB_Clk);
        chk(tag, 32'(acks - a0), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        repeat (3) @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        chk("rst_ack", 32'(Sl_xferAck), 32'd0);
        chk("rst_dbus", Sl_DBus, 32'h0);
        chk("rst_tied", 32'({Sl_errAck, Sl_retry, Sl_toutSup}), 32'd0);
        @(posedge OPB_Clk); #1 OPB_Rst = 1'b0;

        // Reset state
        rd(CTRL, 32'h1, "ctrl_reset");
        for (int i = 0; i < N; i++) rd(i, 32'h0, $sformatf("snap%0d_reset", i));
        rd(STAT, 32'h0, "status_reset");

        // AUTO mode follows captures
        cap(2, 16'hBEEF);
        rd(2, 32'h0000BEEF, "auto_ch2");

        // Manual snapshot
        wr(CTRL, 32'h0, 4'b1111, "ctrl_clear_auto");
        rd(CTRL, 32'h0, "ctrl_auto_off");
        wr(CTRL, 32'h1, 4'b1110, "ctrl_be_masked");
        rd(CTRL, 32'h0, "ctrl_be_ignored");
        cap(0, 16'h0011);
        cap(1, 16'h0022);
        rd(0, 32'h0, "no_snap_yet");
        wr(CTRL, 32'h2, 4'b1111, "snap1");
        rd(CTRL, 32'h0, "snap_reads_zero");
        cap(0, 16'h0099);
        rd(0, 32'h11, "snap1_ch0");
        rd(1, 32'h22, "snap1_ch1");
        wr(CTRL, 32'h2, 4'b1111, "snap2");
        rd(0, 32'h99, "snap2_ch0");

        // Overrun status (AUTO still 0, pending flags cleared by snap2)
        cap(1, 16'h0001);
        rd(STAT, 32'h0, "status_single");
        cap(1, 16'h0002);
        rd(STAT, OVF_EXP, "status_overrun");
        wr(STAT, 32'h40000000, 4'b0111, "status_clear_be_masked");
        rd(STAT, OVF_EXP, "status_be_kept");
        wr(STAT, 32'h40000000, 4'b1111, "status_clear");
        rd(STAT, 32'h0, "status_cleared");

        // Long select yields one ack
        xfer(1'b1, 1, 32'h0, 4'b1111, 32'h22, "long_select", 5);

        // Unmapped offsets in window, and out-of-window selects
        rd(N + 2, 32'h0, "unmapped");
        rd(63, 32'h0, "window_top");
        out_of_window(BASE - 32'd4, "below_window_no_ack");
        out_of_window(HIGH + 32'd1, "above_window_no_ack");

        // Reset during the ACK cycle
        wr(CTRL, 32'h0, 4'b1111, "ctrl_clear_auto2");
        @(posedge OPB_Clk); #1;
        a0 = acks;
        OPB_ABus = BASE + 32'(CTRL * 4); OPB_RNW = 1'b1; OPB_select = 1'b1;
        @(posedge OPB_Clk); #1 OPB_Rst = 1'b1;
        @(negedge OPB_Clk);
        chk("abort_ack", 32'(Sl_xferAck), 32'd0);
        chk("abort_dbus", Sl_DBus, 32'h0);
        @(posedge OPB_Clk); #1 OPB_Rst = 1'b0; OPB_select = 1'b0;
        repeat (2) @(negedge OPB_Clk);
        chk("abort_no_ack", 32'(acks - a0), 32'd0);
        rd(CTRL, 32'h1, "ctrl_after_abort");
        rd(0, 32'h0, "snap0_after_abort");
        rd(1, 32'h0, "snap1_after_abort");

        repeat (2) @(posedge OPB_Clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
